// File: rtl/lcd_scanout_ctrl_if.sv
// Avalon-MM burst read bus between the LCD scanout fetch engine and julia_sys.
// master: scanout controller side; slave: interconnect / memory side.
interface lcd_scanout_ctrl_if;
   logic [31:0] avm_address;
   logic        avm_read;
   logic [3:0]  avm_burstcount;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   modport master (
      output avm_address, avm_read, avm_burstcount,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read, avm_burstcount,
      output avm_waitrequest, avm_readdata, avm_readdatavalid
   );
endinterface

// File: rtl/lcd_scanout_ctrl.sv
// LCD panel scanout: HSD/VSD/DEN timing, pixel FIFO fed by Avalon burst reads.
// Optional macro LCD_SCANOUT_TEST_PATTERN_EN adds pattern_sel and colour-bar output.
module lcd_scanout_ctrl #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FP       = 40,
   parameter int H_SYNC     = 128,
   parameter int H_BP       = 88,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 13,
   parameter int V_SYNC     = 3,
   parameter int V_BP       = 29,
   parameter int BURST      = 8,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic [31:0]               fb_base,
`ifdef LCD_SCANOUT_TEST_PATTERN_EN
   input  logic                      pattern_sel,
`endif
   lcd_scanout_ctrl_if.master        avm,
   output logic [23:0]               RGB,
   output logic                      DEN,
   output logic                      HSD,
   output logic                      VSD,
   output logic                      frame_start,
   output logic                      underflow
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_ACT0  = H_SYNC + H_BP;
   localparam int V_ACT0  = V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;
   localparam logic [31:0] PIX_TOTAL = 32'(H_ACTIVE * V_ACTIVE);

   typedef enum logic [1:0] {IDLE, REQ, DATA} fetch_st_t;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_act, v_act, den_nxt, frame_hit;

   fetch_st_t     state;
   logic [31:0]   addr, remaining, base_lat;
   logic [3:0]    outstanding, bc_nxt;
   logic          restart_pending, flush, can_req;

   logic [23:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          fifo_empty, push, pop, starve;

   logic          pat_on;
   logic [23:0]   bar_rgb;
   logic          unused_rd;

   assign unused_rd = &{1'b0, avm.avm_readdata[31:24]};

   // ---------------- panel timing ----------------
   assign h_act     = (h_cnt >= HW'(H_ACT0)) && (h_cnt < HW'(H_ACT0 + H_ACTIVE));
   assign v_act     = (v_cnt >= VW'(V_ACT0)) && (v_cnt < VW'(V_ACT0 + V_ACTIVE));
   assign den_nxt   = enable && h_act && v_act;
   assign frame_hit = enable && (h_cnt == '0) && (v_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!enable) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == HW'(H_TOTAL - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

`ifdef LCD_SCANOUT_TEST_PATTERN_EN
   logic [HW-1:0] h_x;
   logic [2:0]    bar;
   assign pat_on = pattern_sel;
   assign h_x    = h_cnt - HW'(H_ACT0);
   assign bar    = 3'(h_x / HW'(H_ACTIVE / 8));
   always_comb begin
      bar_rgb = 24'h000000;
      case (bar)
         3'd0: bar_rgb = 24'hFFFFFF;
         3'd1: bar_rgb = 24'hFFFF00;
         3'd2: bar_rgb = 24'h00FFFF;
         3'd3: bar_rgb = 24'h00FF00;
         3'd4: bar_rgb = 24'hFF00FF;
         3'd5: bar_rgb = 24'hFF0000;
         3'd6: bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end
`else
   assign pat_on  = 1'b0;
   assign bar_rgb = 24'h000000;
`endif

   // ---------------- pixel FIFO ----------------
   assign fifo_empty = (count == '0);
   assign push       = (state == DATA) && avm.avm_readdatavalid;
   assign pop        = den_nxt && !pat_on && !fifo_empty;
   assign starve     = den_nxt && !pat_on && fifo_empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= avm.avm_readdata[23:0];
   end

   // Flush wins over a same-cycle pop so a restarted frame always begins empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // ---------------- fetch engine ----------------
   assign flush   = (state == IDLE) && (restart_pending || !enable);
   assign can_req = (32'(count) + 32'(outstanding) + 32'(BURST)) <= 32'(FIFO_DEPTH);
   assign bc_nxt  = (remaining < 32'(BURST)) ? remaining[3:0] : 4'(BURST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         addr               <= '0;
         remaining          <= '0;
         base_lat           <= '0;
         outstanding        <= '0;
         restart_pending    <= 1'b0;
         avm.avm_read       <= 1'b0;
         avm.avm_address    <= '0;
         avm.avm_burstcount <= '0;
      end else begin
         if (frame_hit) begin
            restart_pending <= 1'b1;
            base_lat        <= fb_base;
         end else if (flush) begin
            restart_pending <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (flush) begin
                  // Beats of a burst that straddled the restart are discarded here.
                  if (restart_pending && enable) begin
                     addr      <= base_lat;
                     remaining <= PIX_TOTAL;
                  end else begin
                     remaining <= '0;
                  end
               end else if ((remaining != '0) && can_req && !pat_on) begin
                  state              <= REQ;
                  avm.avm_read       <= 1'b1;
                  avm.avm_address    <= addr;
                  avm.avm_burstcount <= bc_nxt;
               end
            end
            REQ: begin
               if (!avm.avm_waitrequest) begin
                  state        <= DATA;
                  avm.avm_read <= 1'b0;
                  outstanding  <= avm.avm_burstcount;
                  addr         <= addr + {26'd0, avm.avm_burstcount, 2'b00};
                  remaining    <= remaining - 32'(avm.avm_burstcount);
               end
            end
            DATA: begin
               if (avm.avm_readdatavalid) begin
                  outstanding <= outstanding - 1'b1;
                  if (outstanding == 4'd1) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------- registered panel outputs ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         RGB         <= '0;
         DEN         <= 1'b0;
         HSD         <= 1'b1;
         VSD         <= 1'b1;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         HSD         <= !(enable && (h_cnt < HW'(H_SYNC)));
         VSD         <= !(enable && (v_cnt < VW'(V_SYNC)));
         DEN         <= den_nxt;
         frame_start <= frame_hit;
         if (starve) underflow <= 1'b1;
         if (!den_nxt)        RGB <= '0;
         else if (pat_on)     RGB <= bar_rgb;
         else if (fifo_empty) RGB <= '0;
         else                 RGB <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_lcd_scanout_ctrl.sv
// Directed bench for lcd_scanout_ctrl on a 14x7 panel with a scripted Avalon slave.
module tb_lcd_scanout_ctrl;
   localparam int FRAME = 98;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [31:0] fb_base;
   logic        pattern_sel;
   logic [23:0] rgb;
   logic        den, hsd, vsd, fs, underflow;

   lcd_scanout_ctrl_if bus();

   lcd_scanout_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .BURST(4), .FIFO_DEPTH(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .fb_base(fb_base),
`ifdef LCD_SCANOUT_TEST_PATTERN_EN
      .pattern_sel(pattern_sel),
`endif
      .avm(bus.master), .RGB(rgb), .DEN(den), .HSD(hsd), .VSD(vsd),
      .frame_start(fs), .underflow(underflow)
   );

   initial forever #5 clk = ~clk;

   int n_tests = 0, n_fail = 0, cyc = 0;
   int lat = 1, n_stall = 0;
   bit stall_mode = 0;
   logic [31:0] bq_addr[$];
   logic [3:0]  bq_bc[$];
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [23:0] pix[$];
   int n_hsd, n_hsd_l0, n_vsd, n_den, n_fs, fs_ok, good_lines, max_read;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Avalon slave: data word = (address - 0x100) / 4, fixed latency, optional stalls.
   initial begin
      bit held = 0;
      int stall_left = 0;
      logic [31:0] h_addr;
      logic [3:0]  h_bc;
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            pend_addr.delete(); pend_due.delete();
            held = 0; stall_left = 0;
            bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0;
         end else begin
            if (held) begin
               chk("stall_read", 32'(bus.avm_read), 1);
               chk("stall_addr", bus.avm_address, h_addr);
               chk("stall_bc", 32'(bus.avm_burstcount), 32'(h_bc));
            end
            held = 0;
            bus.avm_waitrequest = 1'b0;
            if (bus.avm_read) begin
               if (stall_left > 0) begin
                  bus.avm_waitrequest = 1'b1;
                  stall_left--; n_stall++;
                  held = 1; h_addr = bus.avm_address; h_bc = bus.avm_burstcount;
               end else begin
                  bq_addr.push_back(bus.avm_address);
                  bq_bc.push_back(bus.avm_burstcount);
                  for (int b = 0; b < int'(bus.avm_burstcount); b++) begin
                     pend_addr.push_back(bus.avm_address + 32'(4 * b));
                     pend_due.push_back(cyc + 1 + lat + b);
                  end
                  stall_left = stall_mode ? int'($urandom_range(0, 3)) : 0;
               end
            end
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = '0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
               bus.avm_readdatavalid = 1'b1;
               bus.avm_readdata      = (pend_addr[0] - 32'h100) >> 2;
               void'(pend_addr.pop_front());
               void'(pend_due.pop_front());
            end
         end
      end
   end

   // Align on frame_start, then sample nfr frames of panel outputs.
   task automatic run_frames(input int nfr, input int chg_cyc, input logic [31:0] chg_val);
      int k = 0, line_den = 0;
      n_hsd = 0; n_hsd_l0 = 0; n_vsd = 0; n_den = 0; n_fs = 0; fs_ok = 0;
      good_lines = 0; max_read = 0; pix.delete();
      do begin @(negedge clk); k++; end while (!fs && k < 300);
      if (!fs) begin chk("fs_wait", 0, 1); return; end
      for (int i = 0; i < nfr * FRAME; i++) begin
         if (i == chg_cyc) fb_base = chg_val;
         if (!hsd) begin n_hsd++; if (i < 14) n_hsd_l0++; end
         if (!vsd) n_vsd++;
         if (fs) begin n_fs++; if (i % FRAME == 0) fs_ok++; end
         if (den) begin n_den++; line_den++; pix.push_back(rgb); end
         if (bus.avm_read) max_read = 1;
         if (i % 14 == 13) begin if (line_den == 8) good_lines++; line_den = 0; end
         @(negedge clk);
      end
   endtask

   task automatic check_timing(input int nfr);
      chk("hsd_low_line", n_hsd_l0, 2);
      chk("hsd_low", n_hsd, 14 * nfr);
      chk("vsd_low", n_vsd, 14 * nfr);
      chk("den_high", n_den, 32 * nfr);
      chk("den_lines", good_lines, 4 * nfr);
      chk("fs_count", n_fs, nfr);
      chk("fs_period", fs_ok, nfr);
   endtask

   task automatic check_pix(input string tag, input int nfr);
      chk({tag, "_n"}, pix.size(), 32 * nfr);
      for (int i = 0; i < pix.size(); i++) chk(tag, 32'(pix[i]), 32'(i % 32));
   endtask

   initial begin
      int k, nb, zeros, nz, bad;
      logic [23:0] prev;
      reset_n = 1'b0; enable = 1'b0; fb_base = 32'h100; pattern_sel = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rgb", 32'(rgb), 0);      chk("rst_den", 32'(den), 0);
      chk("rst_hsd", 32'(hsd), 1);      chk("rst_vsd", 32'(vsd), 1);
      chk("rst_read", 32'(bus.avm_read), 0);
      chk("rst_addr", bus.avm_address, 0);
      chk("rst_bc", 32'(bus.avm_burstcount), 0);
      chk("rst_fs", 32'(fs), 0);        chk("rst_uf", 32'(underflow), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("dis_read", 32'(bus.avm_read), 0);
      chk("dis_hsd", 32'(hsd), 1);

      // Timing and nominal fetch over three frames.
      enable = 1'b1;
      run_frames(3, -1, 0);
      check_timing(3);
      check_pix("pix_nom", 3);
      chk("nom_uf", 32'(underflow), 0);
      chk("nom_bursts", bq_addr.size(), 24);
      for (int i = 0; i < bq_addr.size() && i < 24; i++) begin
         chk("burst_addr", bq_addr[i], 32'h100 + 32'(16 * (i % 8)));
         chk("burst_bc", 32'(bq_bc[i]), 4);
      end

      // Random waitrequest stalls.
      stall_mode = 1;
      run_frames(2, -1, 0);
      check_pix("pix_stall", 2);
      chk("stall_seen", 32'(n_stall > 0), 1);
      chk("stall_uf", 32'(underflow), 0);
      stall_mode = 0;

      // fb_base change mid-frame takes effect at the next frame.
      run_frames(1, 40, 32'h2000);
      check_pix("pix_base", 1);
      for (int i = 0; i < 8; i++)
         chk("old_base_addr", bq_addr[bq_addr.size() - 8 + i], 32'h100 + 32'(16 * i));
      nb = bq_addr.size();
      repeat (30) @(negedge clk);
      chk("new_base_seen", 32'(bq_addr.size() > nb), 1);
      if (bq_addr.size() > nb) chk("new_base_addr", bq_addr[nb], 32'h2000);

      // enable low: outputs idle, underflow holds.
      enable = 1'b0;
      repeat (30) @(negedge clk);
      chk("off_den", 32'(den), 0);   chk("off_rgb", 32'(rgb), 0);
      chk("off_hsd", 32'(hsd), 1);   chk("off_vsd", 32'(vsd), 1);
      chk("off_fs", 32'(fs), 0);     chk("off_read", 32'(bus.avm_read), 0);
      chk("off_uf", 32'(underflow), 0);

      // Long read latency starves the first line.
      lat = 40;
      enable = 1'b1;
      run_frames(1, -1, 0);
      check_timing(1);
      chk("slow_uf", 32'(underflow), 1);
      zeros = 0; nz = 0; bad = 0; prev = '0;
      for (int i = 0; i < pix.size(); i++) begin
         if (i < 8 && pix[i] == 24'd0) zeros++;
         if (pix[i] != 24'd0) begin
            if (nz > 0 && pix[i] != prev + 24'd1) bad++;
            prev = pix[i]; nz++;
         end
      end
      chk("slow_line0_zero", zeros, 8);
      chk("slow_some_data", 32'(nz > 0), 1);
      chk("slow_order", bad, 0);

      // Reset in the middle of an outstanding burst.
      k = 0;
      do begin @(negedge clk); #2; k++; end while (pend_due.size() == 0 && k < 200);
      chk("midburst_seen", 32'(pend_due.size() > 0), 1);
      reset_n = 1'b0;
      #1;
      chk("mrst_rgb", 32'(rgb), 0);      chk("mrst_den", 32'(den), 0);
      chk("mrst_hsd", 32'(hsd), 1);      chk("mrst_vsd", 32'(vsd), 1);
      chk("mrst_read", 32'(bus.avm_read), 0);
      chk("mrst_addr", bus.avm_address, 0);
      chk("mrst_bc", 32'(bus.avm_burstcount), 0);
      chk("mrst_fs", 32'(fs), 0);        chk("mrst_uf", 32'(underflow), 0);
      repeat (3) @(negedge clk);
      lat = 1; fb_base = 32'h100;
`ifdef LCD_SCANOUT_TEST_PATTERN_EN
      pattern_sel = 1'b1;
`endif
      reset_n = 1'b1;
      nb = bq_addr.size();
      run_frames(1, -1, 0);
      check_timing(1);
      chk("post_uf", 32'(underflow), 0);
`ifdef LCD_SCANOUT_TEST_PATTERN_EN
      chk("bar_n", pix.size(), 32);
      for (int i = 0; i < pix.size(); i++) chk("bar_rgb", 32'(pix[i]), 32'(bars[i % 8]));
      chk("bar_no_read", max_read, 0);
      chk("bar_no_burst", bq_addr.size(), nb);
`else
      check_pix("pix_post", 1);
      chk("post_bursts", bq_addr.size() - nb, 8);
      if (bq_addr.size() - nb >= 1) chk("post_addr0", bq_addr[nb], 32'h100);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
